// File: rtl/ecc_ram_scrubber.sv
// ecc_ram_scrubber
//   Background scrubber for one port of the soft ECC RAM. A pass walks every
//   address from 0 to NUM_WORDS-1. For each address it issues a read, waits
//   RAM_RD_LATENCY cycles, then samples ram_q/ram_err:
//     err[1]        -> uncorrectable, counted, no write-back
//     err[0] only   -> correctable, counted, corrected word written back
//   The error counters saturate at all-ones and hold until the next start.
//
// Build option: define SCRUB_LOG_EN to log the address of the first
//   uncorrectable word of a pass. Without it first_bad_* are tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse, begins a pass (only accepted when idle)
//   hold                  pauses the scrubber before the next read issue
//   ram_address/data/wren RAM port driven by the scrubber
//   ram_q, ram_err        RAM read data (already corrected) and err flags
//   busy, done            pass in progress / one-cycle completion pulse
//   corr_count            correctable words seen this pass (saturating)
//   uncorr_count          uncorrectable words seen this pass (saturating)
//   first_bad_addr/vld    first uncorrectable address of the pass
module ecc_ram_scrubber #(
  parameter int NUM_WORDS      = 512,
  parameter int DATA_BITS      = 64,
  parameter int RAM_RD_LATENCY = 4,
  parameter int CNT_WIDTH      = 16,
  localparam int ADDR_WIDTH    = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_BITS-1:0]  ram_data,
  output logic                  ram_wren,
  input  logic [DATA_BITS-1:0]  ram_q,
  input  logic [2:0]            ram_err,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count,
  output logic [ADDR_WIDTH-1:0] first_bad_addr,
  output logic                  first_bad_vld
);

  localparam int LAT_W = (RAM_RD_LATENCY > 1) ? $clog2(RAM_RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(RAM_RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [LAT_W-1:0] lat;
  logic             sample;
  logic             at_last;
  logic             unused_err;

  // err[2] carries no meaning for the scrubber
  assign unused_err = ram_err[2];

  // the read issued in ISSUE is valid on the last WAIT cycle
  assign sample  = (state == S_WAIT) && (lat == '0);
  assign at_last = (ram_address == LAST_ADDR);

  // decoded straight from state so that reset drops the write enable at once
  assign ram_wren = (state == S_WRITE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      lat          <= '0;
      ram_address  <= '0;
      ram_data     <= '0;
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            corr_count   <= '0;
            uncorr_count <= '0;
            ram_address  <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            lat   <= LAT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!sample) begin
            lat <= lat - 1'b1;
          end else if (ram_err[1]) begin
            // uncorrectable wins over correctable when both are flagged
            if (uncorr_count != '1) uncorr_count <= uncorr_count + 1'b1;
            if (at_last) state <= S_DONE;
            else begin
              ram_address <= ram_address + 1'b1;
              state       <= S_ISSUE;
            end
          end else if (ram_err[0]) begin
            if (corr_count != '1) corr_count <= corr_count + 1'b1;
            ram_data <= ram_q;
            state    <= S_WRITE;
          end else begin
            if (at_last) state <= S_DONE;
            else begin
              ram_address <= ram_address + 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_WRITE: begin
          if (at_last) state <= S_DONE;
          else begin
            ram_address <= ram_address + 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCRUB_LOG_EN
  logic [ADDR_WIDTH-1:0] bad_addr;
  logic                  bad_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_addr <= '0;
      bad_vld  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      bad_addr <= '0;
      bad_vld  <= 1'b0;
    end else if (sample && ram_err[1] && !bad_vld) begin
      bad_addr <= ram_address;
      bad_vld  <= 1'b1;
    end
  end

  assign first_bad_addr = bad_addr;
  assign first_bad_vld  = bad_vld;
`else
  assign first_bad_addr = '0;
  assign first_bad_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_ram_scrubber.sv
// Bench for ecc_ram_scrubber. Two instances: the default 512-word build with a
// 4-cycle RAM, and a 16-word, 1-cycle, 2-bit-counter build for saturation.
// The RAM model holds the true data plus an injected err code per word; a
// write-back clears the injected error.
module tb_ecc_ram_scrubber;
  localparam int NW = 512;
  localparam int L  = 4;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] ram_address;
  logic [63:0]   ram_data, ram_q;
  logic          ram_wren;
  logic [2:0]    ram_err;
  logic          busy, done;
  logic [15:0]   corr_count, uncorr_count;
  logic [AW-1:0] first_bad_addr;
  logic          first_bad_vld;

  logic [63:0]   mem  [NW];
  logic [2:0]    flip [NW];
  logic [AW-1:0] ap   [L];

  int checks = 0;
  int failures = 0;

  int  exp_cycles, exp_corr, exp_uncorr, exp_first;
  bit  exp_first_vld;
  logic [AW+63:0] exp_wr[$];
  logic [AW+63:0] wr_q[$];

  always #5 clk = ~clk;

  ecc_ram_scrubber #(.NUM_WORDS(NW), .DATA_BITS(64), .RAM_RD_LATENCY(L), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .ram_err(ram_err), .busy(busy), .done(done),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .first_bad_addr(first_bad_addr), .first_bad_vld(first_bad_vld)
  );

  // read pipeline: data for the address of cycle t shows up in cycle t+L
  always @(posedge clk) begin
    ap[0] <= ram_address;
    for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
  end
  assign ram_q   = mem[ap[L-1]];
  assign ram_err = flip[ap[L-1]];

  // small instance for counter saturation and minimum latency
  logic        start2 = 1'b0;
  logic [3:0]  addr2, ap2, fba2;
  logic [63:0] data2, q2;
  logic        wren2, busy2, done2, fbv2;
  logic [2:0]  err2;
  logic [1:0]  corr2, uncorr2;
  logic [63:0] mem2  [16];
  logic [2:0]  flip2 [16];

  ecc_ram_scrubber #(.NUM_WORDS(16), .DATA_BITS(64), .RAM_RD_LATENCY(1), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .hold(1'b0),
    .ram_address(addr2), .ram_data(data2), .ram_wren(wren2),
    .ram_q(q2), .ram_err(err2), .busy(busy2), .done(done2),
    .corr_count(corr2), .uncorr_count(uncorr2),
    .first_bad_addr(fba2), .first_bad_vld(fbv2)
  );

  always @(posedge clk) ap2 <= addr2;
  assign q2   = mem2[ap2];
  assign err2 = flip2[ap2];

  // random contents; clean words may carry a junk err[2] bit
  task automatic init_mem();
    for (int a = 0; a < NW; a++) begin
      mem[a]  = {$urandom(), $urandom()};
      flip[a] = {1'($urandom()), 2'b00};
    end
  endtask

  // reference: a pass costs (1+L) per word, +1 per word that is correctable
  // only, plus every held cycle; write-backs come out in address order
  task automatic predict(input int hold_len);
    exp_cycles = NW * (1 + L) + hold_len;
    exp_corr = 0; exp_uncorr = 0; exp_first = 0; exp_first_vld = 0;
    exp_wr.delete();
    for (int a = 0; a < NW; a++) begin
      if (flip[a][1]) begin
        exp_uncorr++;
        if (!exp_first_vld) begin exp_first_vld = 1; exp_first = a; end
      end else if (flip[a][0]) begin
        exp_corr++;
        exp_cycles++;
        exp_wr.push_back({AW'(a), mem[a]});
      end
    end
`ifndef SCRUB_LOG_EN
    exp_first = 0; exp_first_vld = 0;
`endif
  endtask

  // one pass; cycles = clock edges from the accepting edge to the done cycle
  task automatic run_pass(input int hold_addr, input int hold_len, input int mid_start,
                          output int cycles, output bit hold_bad);
    int hc; bit holding;
    cycles = 0; hc = 0; holding = 0; hold_bad = 0;
    wr_q.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ram_address !== '0) begin
      failures++;
      $display("FAIL start_accept busy=%0b addr=%0d expected busy=1 addr=0", busy, ram_address);
    end
    while (done !== 1'b1 && cycles < 20000) begin
      if (ram_wren === 1'b1) begin
        wr_q.push_back({ram_address, ram_data});
        mem[ram_address]  = ram_data;
        flip[ram_address] = 3'b000;
      end
      if (holding && (ram_address !== AW'(hold_addr) || ram_wren !== 1'b0)) hold_bad = 1;
      if (!holding && hc == 0 && hold_len > 0 && ram_address == AW'(hold_addr)) begin
        hold = 1'b1; holding = 1;
      end
      start = (cycles == mid_start);
      @(posedge clk);
      cycles++;
      if (holding) hc++;
      @(negedge clk);
      if (holding && hc == hold_len) begin hold = 1'b0; holding = 0; end
    end
    start = 1'b0; hold = 1'b0;
    if (cycles >= 20000) begin
      failures++;
      $display("FAIL pass_timeout cycles=%0d", cycles);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_end done=%0b busy=%0b expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ram_address, ram_data, ram_wren} !== '0) begin
      failures++;
      $display("FAIL reset_port addr=%0d data=%h wren=%0b expected 0", ram_address, ram_data, ram_wren);
    end
    checks++;
    if ({busy, done, corr_count, uncorr_count} !== '0) begin
      failures++;
      $display("FAIL reset_status busy=%0b done=%0b corr=%0d uncorr=%0d expected 0",
               busy, done, corr_count, uncorr_count);
    end
    checks++;
    if ({first_bad_addr, first_bad_vld} !== '0) begin
      failures++;
      $display("FAIL reset_log addr=%0d vld=%0b expected 0", first_bad_addr, first_bad_vld);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_clean();
    int cyc; bit hb;
    init_mem();
    predict(0);
    run_pass(-1, 0, -1, cyc, hb);
    checks++;
    if (cyc != 2560 || cyc != exp_cycles) begin
      failures++; $display("FAIL clean_length got=%0d expected=2560", cyc);
    end
    checks++;
    if (corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
      failures++; $display("FAIL clean_counts corr=%0d uncorr=%0d expected 0 0", corr_count, uncorr_count);
    end
    checks++;
    if (wr_q.size() != 0) begin
      failures++; $display("FAIL clean_writes got=%0d expected=0", wr_q.size());
    end
  endtask

  task automatic test_single();
    int cyc; bit hb; logic [63:0] orig;
    init_mem();
    flip[37] = 3'b101;
    orig = mem[37];
    predict(0);
    run_pass(-1, 0, -1, cyc, hb);
    checks++;
    if (cyc != 2561) begin failures++; $display("FAIL single_length got=%0d expected=2561", cyc); end
    checks++;
    if (corr_count !== 16'd1 || uncorr_count !== 16'd0) begin
      failures++; $display("FAIL single_counts corr=%0d uncorr=%0d expected 1 0", corr_count, uncorr_count);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {AW'(37), orig}) begin
      failures++;
      $display("FAIL single_write n=%0d first=%h expected 1 write %h", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : '0, {AW'(37), orig});
    end
    predict(0);
    run_pass(-1, 0, -1, cyc, hb);
    checks++;
    if (corr_count !== 16'd0 || cyc != 2560 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL single_rescrub corr=%0d len=%0d writes=%0d expected 0 2560 0", corr_count, cyc, wr_q.size());
    end
  endtask

  task automatic test_double();
    int cyc; bit hb;
    init_mem();
    flip[100] = 3'b010;
    flip[300] = 3'b011;  // both bits: uncorrectable takes priority
    predict(0);
    run_pass(-1, 0, -1, cyc, hb);
    checks++;
    if (uncorr_count !== 16'd2 || corr_count !== 16'd0) begin
      failures++; $display("FAIL double_counts corr=%0d uncorr=%0d expected 0 2", corr_count, uncorr_count);
    end
    checks++;
    if (wr_q.size() != 0 || cyc != 2560) begin
      failures++; $display("FAIL double_writes writes=%0d len=%0d expected 0 2560", wr_q.size(), cyc);
    end
    checks++;
    if (first_bad_addr !== AW'(exp_first) || first_bad_vld !== exp_first_vld) begin
      failures++;
      $display("FAIL double_log addr=%0d vld=%0b expected %0d %0b", first_bad_addr, first_bad_vld,
               exp_first, exp_first_vld);
    end
  endtask

  task automatic test_hold();
    int cyc; bit hb;
    init_mem();
    predict(50);
    run_pass(10, 50, -1, cyc, hb);
    checks++;
    if (cyc != 2610 || cyc != exp_cycles) begin
      failures++; $display("FAIL hold_length got=%0d expected=2610", cyc);
    end
    checks++;
    if (hb) begin failures++; $display("FAIL hold_stall address moved or write seen while held"); end
  endtask

  task automatic test_reset_in_write();
    int n, cyc; bit hb;
    init_mem();
    flip[37] = 3'b001;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (ram_wren !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (ram_wren !== 1'b1 || ram_address !== AW'(37)) begin
      failures++; $display("FAIL rst_write_seen wren=%0b addr=%0d expected 1 37", ram_wren, ram_address);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || busy !== 1'b0 || corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_async wren=%0b busy=%0b corr=%0d uncorr=%0d expected 0", ram_wren, busy,
               corr_count, uncorr_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    // the dropped write leaves the error in place for the next pass
    predict(0);
    run_pass(-1, 0, -1, cyc, hb);
    checks++;
    if (cyc != 2561 || corr_count !== 16'd1 || wr_q.size() != 1) begin
      failures++;
      $display("FAIL rst_rescrub len=%0d corr=%0d writes=%0d expected 2561 1 1", cyc, corr_count, wr_q.size());
    end
  endtask

  // random errors, random hold and an ignored start mid-pass, back to back
  task automatic test_random();
    int cyc, ha, hl, ms; bit hb, ok;
    for (int it = 0; it < 3; it++) begin
      init_mem();
      for (int k = 0; k < 8; k++)
        flip[$urandom_range(0, NW-1)] = {1'($urandom()), 2'($urandom_range(1, 3))};
      ha = $urandom_range(0, NW-1);
      hl = $urandom_range(1, 20);
      ms = $urandom_range(5, 2000);
      predict(hl);
      run_pass(ha, hl, ms, cyc, hb);
      checks++;
      if (cyc != exp_cycles || hb) begin
        failures++; $display("FAIL rand%0d_length got=%0d expected=%0d hold_bad=%0b", it, cyc, exp_cycles, hb);
      end
      checks++;
      if (corr_count !== 16'(exp_corr) || uncorr_count !== 16'(exp_uncorr)) begin
        failures++;
        $display("FAIL rand%0d_counts corr=%0d uncorr=%0d expected %0d %0d", it, corr_count,
                 uncorr_count, exp_corr, exp_uncorr);
      end
      ok = (wr_q.size() == exp_wr.size());
      for (int i = 0; ok && i < wr_q.size(); i++) if (wr_q[i] !== exp_wr[i]) ok = 0;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rand%0d_writes got=%0d expected=%0d (or data differ)", it, wr_q.size(), exp_wr.size());
      end
      checks++;
      if (first_bad_addr !== AW'(exp_first) || first_bad_vld !== exp_first_vld) begin
        failures++;
        $display("FAIL rand%0d_log addr=%0d vld=%0b expected %0d %0b", it, first_bad_addr,
                 first_bad_vld, exp_first, exp_first_vld);
      end
    end
  endtask

  task automatic test_saturate();
    int n, wr, ef; bit ev;
    for (int a = 0; a < 16; a++) begin
      mem2[a]  = {$urandom(), $urandom()};
      flip2[a] = 3'b000;
    end
    for (int a = 1; a <= 9; a += 2) flip2[a] = 3'b001;
    for (int a = 11; a <= 14; a++) flip2[a] = 3'b010;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk);
    @(negedge clk); start2 = 1'b0;
    n = 0; wr = 0;
    while (done2 !== 1'b1 && n < 500) begin
      if (wren2 === 1'b1) begin
        wr++;
        mem2[addr2] = data2; flip2[addr2] = 3'b000;
      end
      start2 = (n == 10);
      @(posedge clk); n++;
      @(negedge clk);
    end
    start2 = 1'b0;
    checks++;
    if (n != 16 * 2 + 5) begin failures++; $display("FAIL sat_length got=%0d expected=37", n); end
    checks++;
    if (corr2 !== 2'd3 || uncorr2 !== 2'd3) begin
      failures++; $display("FAIL sat_counts corr=%0d uncorr=%0d expected 3 3", corr2, uncorr2);
    end
    checks++;
    if (wr != 5) begin failures++; $display("FAIL sat_writes got=%0d expected=5", wr); end
`ifdef SCRUB_LOG_EN
    ef = 11; ev = 1;
`else
    ef = 0; ev = 0;
`endif
    checks++;
    if (fba2 !== 4'(ef) || fbv2 !== ev) begin
      failures++; $display("FAIL sat_log addr=%0d vld=%0b expected %0d %0b", fba2, fbv2, ef, ev);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_hold();
    test_reset_in_write();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
